mc14500_sequencer: RTL and testbench
====================================

# mc14500_sequencer

Instruction sequencer for the MC14500B 8-bit-instruction system. Holds the program counter, drives the 128×8 program ROM address, latches each instruction byte and presents it to the ICU as opcode + I/O address. Implements JMP (two-byte, optional call), RTN, SKZ and halt in the sequencer, with a small return stack.

## Interface
Parameters:
- ADDR_W, 7, program counter / ROM address width
- STACK_DEPTH, 4, return-stack entries (power of two, ≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  high = fetch enabled; low = stall in FETCH
- rom_addr  out  ADDR_W  ROM address, driven directly from the PC/operand-address register
- rom_data  in  8  ROM byte; combinational from rom_addr, valid in the same cycle
- icu_rr  in  1  ICU result register, used by SKZ
- instr_op  out  4  opcode of the current instruction, ir[7:4]
- instr_addr  out  4  I/O address field, ir[3:0]
- instr_valid  out  1  one-cycle strobe: ICU executes instr_op/instr_addr this cycle
- flag0  out  1  one-cycle pulse on NOP0
- flagf  out  1  one-cycle pulse on NOPF
- halted  out  1  high while in HALT
- stack_err  out  1  sticky; set on overflow or underflow, cleared only by rst

## Operation
- Instruction byte = {op[3:0], io_addr[3:0]}. Opcodes: 0 NOP0, 1 LD, 2 LDC, 3 AND, 4 ANDC, 5 OR, 6 ORC, 7 XNOR, 8 STO, 9 STOC, A IEN, B OEN, C JMP, D RTN, E SKZ, F NOPF.
- States: FETCH, EXEC, OPND, HALT.
- FETCH: if run, ir <= rom_data, pc <= pc+1 → EXEC; else hold.
- EXEC: instr_valid=1 for exactly this cycle; ICU sees every opcode, including C/D/E/F. Then:
  - C JMP → OPND. pc already points at the operand byte.
  - D RTN: stack empty → stack_err=1, HALT; else pc <= pop → FETCH.
  - E SKZ: icu_rr==0 → pc <= pc+1 (skip one byte) → FETCH; else → FETCH.
  - F NOPF: flagf=1. If io_addr==4'hF → HALT, else → FETCH.
  - 0 NOP0: flag0=1 → FETCH.
  - others → FETCH.
- OPND: operand = rom_data at pc. If operand[7]==1 (call), push pc+1; if stack full, stack_err=1 and → HALT without jumping. Otherwise pc <= operand[6:0] → FETCH.
- HALT: no fetch, halted=1. Exit only via rst.
- PC arithmetic is modulo 2^ADDR_W: 127+1=0. This applies to fetch increment, SKZ skip and the pushed return address.
- SKZ skips exactly one byte. Skipping the first byte of a JMP lands on its operand byte, which is then executed as an instruction. This is the programmer's responsibility.
- Stack: LIFO, depth STACK_DEPTH, with an occupancy counter 0..STACK_DEPTH. A push at count==STACK_DEPTH is an overflow. A pop at count==0 is an underflow.

## Timing
- Reset values: pc=0, rom_addr=0, ir=0, state=FETCH, stack count=0, instr_valid=0, flag0=0, flagf=0, halted=0, stack_err=0, instr_op=0, instr_addr=0.
- Normal instruction: 2 cycles (FETCH, EXEC). JMP: 3 cycles (FETCH, EXEC, OPND).
- instr_op/instr_addr are registered, stable from EXEC until the next FETCH completes.
- flag0/flagf are asserted in the same cycle as the instr_valid they belong to.
- icu_rr is sampled in the SKZ EXEC cycle. It must reflect RR from the previous instruction.
- run is sampled only in FETCH. Deasserting run during EXEC/OPND completes the instruction, then stalls.
- rst overrides every state, including HALT and mid-JMP; the stack is emptied.

## Test plan
- Linear: ROM[0..2]=0x11,0x38,0x82, run=1 from reset → instr_valid at cycles 1,3,5 with (op,addr)=(1,1),(3,8),(8,2); rom_addr 0,1,1,2,2,3.
- Call/return: ROM[0]=0xC0, ROM[1]=0x90, ROM[0x10]=0xD0 → after RTN, the next fetch is at rom_addr=2. Stack count goes 1 then 0. stack_err=0.
- SKZ: ROM[4]=0xE0 with icu_rr=0 → next fetch at 6. With icu_rr=1 → next fetch at 5.
- Halt/flags: NOP0 at ROM[0] → flag0 pulse 1 cycle. ROM[1]=0xFF → flagf pulse, then halted=1 and rom_addr frozen at 2 for ≥10 cycles. rst → pc=0, halted=0.
- Stack errors: RTN with empty stack → stack_err=1, halted=1. Five nested calls with STACK_DEPTH=4 → 5th call sets stack_err, halts, pc not loaded.
- Wrap/stall: ROM[127]=0x10 → next fetch at rom_addr=0. run=0 held 5 cycles in FETCH → no instr_valid, rom_addr unchanged.

Source files
------------

// File: rtl/mc14500_sequencer.sv
// Instruction sequencer for an MC14500B system: program counter, instruction latch,
// two-byte JMP/call, RTN with a small return stack, SKZ and halt.
module mc14500_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              icu_rr,
  output logic [3:0]        instr_op,
  output logic [3:0]        instr_addr,
  output logic              instr_valid,
  output logic              flag0,
  output logic              flagf,
  output logic              halted,
  output logic              stack_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {FETCH, EXEC, OPND, HALT} state_e;
  typedef enum logic [3:0] {
    OP_NOP0 = 4'h0, OP_JMP = 4'hC, OP_RTN = 4'hD, OP_SKZ = 4'hE, OP_NOPF = 4'hF
  } op_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        ir_q;
  logic [CNT_W-1:0]  count_q;
  logic              instr_valid_q, flag0_q, flagf_q, halted_q, stack_err_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [SP_W-1:0]   pop_idx;
  logic              push_en;

  // Modulo-2^ADDR_W increment shared by fetch, SKZ skip and the return address.
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pop_idx = SP_W'(count_q - CNT_W'(1));
  assign push_en = !rst && state_q == OPND && rom_data[7] && count_q != FULL;

  // NOTE: the return-stack storage has no reset; occupancy is tracked by count_q,
  // so stale entries are never read and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[count_q[SP_W-1:0]] <= pc_inc;
  end

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      flag0_q       <= 1'b0;
      flagf_q       <= 1'b0;
      halted_q      <= 1'b0;
      stack_err_q   <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      flag0_q       <= 1'b0;
      flagf_q       <= 1'b0;
      case (state_q)
        FETCH: begin
          if (run) begin
            ir_q          <= rom_data;
            pc_q          <= pc_inc;
            state_q       <= EXEC;
            instr_valid_q <= 1'b1;
            flag0_q       <= rom_data[7:4] == OP_NOP0;
            flagf_q       <= rom_data[7:4] == OP_NOPF;
          end
        end
        EXEC: begin
          case (op_e'(ir_q[7:4]))
            OP_JMP: state_q <= OPND;
            OP_RTN: begin
              if (count_q == '0) begin
                stack_err_q <= 1'b1;
                halted_q    <= 1'b1;
                state_q     <= HALT;
              end else begin
                pc_q    <= stack_q[pop_idx];
                count_q <= count_q - CNT_W'(1);
                state_q <= FETCH;
              end
            end
            OP_SKZ: begin
              if (!icu_rr) pc_q <= pc_inc;
              state_q <= FETCH;
            end
            OP_NOPF: begin
              if (ir_q[3:0] == 4'hF) begin
                halted_q <= 1'b1;
                state_q  <= HALT;
              end else begin
                state_q <= FETCH;
              end
            end
            default: state_q <= FETCH;
          endcase
        end
        OPND: begin
          // A call into a full stack halts with pc still on the operand byte.
          if (rom_data[7] && count_q == FULL) begin
            stack_err_q <= 1'b1;
            halted_q    <= 1'b1;
            state_q     <= HALT;
          end else begin
            if (rom_data[7]) count_q <= count_q + CNT_W'(1);
            pc_q    <= ADDR_W'(rom_data[6:0]);
            state_q <= FETCH;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign instr_op    = ir_q[7:4];
  assign instr_addr  = ir_q[3:0];
  assign instr_valid = instr_valid_q;
  assign flag0       = flag0_q;
  assign flagf       = flagf_q;
  assign halted      = halted_q;
  assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed bench for mc14500_sequencer: a behavioural ROM array and per-scenario
// tasks with hand-computed expected cycle-by-cycle values.
module tb_mc14500_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       icu_rr = 1'b0;
  logic [3:0] instr_op, instr_addr;
  logic       instr_valid, flag0, flagf, halted, stack_err;

  logic [7:0] rom [128];
  int n_pass  = 0;
  int n_total = 0;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  mc14500_sequencer #(.ADDR_W(7), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .icu_rr(icu_rr), .instr_op(instr_op), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .flag0(flag0), .flagf(flagf), .halted(halted),
    .stack_err(stack_err)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fill with LD 1 so unused locations neither pulse flags nor branch.
  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 8'h11;
  endtask

  // Leaves the bench 1 time unit after the last reset edge: that is cycle 0 (FETCH @0).
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b1;
    step(2);
    n_total++;
    if ({rom_addr, instr_op, instr_addr, instr_valid, flag0, flagf, halted, stack_err} !== 20'h0)
      $display("FAIL reset_outputs: got addr=%0h op=%0h ia=%0h v=%b f0=%b ff=%b h=%b e=%b, want all 0",
               rom_addr, instr_op, instr_addr, instr_valid, flag0, flagf, halted, stack_err);
    else n_pass++;
  endtask

  task automatic test_linear();
    logic [7:0] prog [3];
    prog[0] = 8'h11; prog[1] = 8'h38; prog[2] = 8'h82;
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = prog[i];
    run = 1'b1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      n_total++;
      if (rom_addr !== 7'((c + 1) / 2) || instr_valid !== 1'(c % 2))
        $display("FAIL linear_c%0d: got addr=%0d valid=%b, want addr=%0d valid=%b",
                 c, rom_addr, instr_valid, (c + 1) / 2, c % 2);
      else n_pass++;
      if (c % 2 == 1) begin
        n_total++;
        if ({instr_op, instr_addr} !== prog[(c - 1) / 2])
          $display("FAIL linear_instr_c%0d: got %0h%0h, want %02h", c, instr_op, instr_addr,
                   prog[(c - 1) / 2]);
        else n_pass++;
      end
      step(1);
    end
  endtask

  task automatic test_call_return();
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h90; rom[7'h10] = 8'hD0;
    run = 1'b1;
    do_reset();
    step(1);  // c1: EXEC JMP
    n_total++;
    if (instr_valid !== 1'b1 || instr_op !== 4'hC)
      $display("FAIL call_exec: got valid=%b op=%0h, want valid=1 op=c", instr_valid, instr_op);
    else n_pass++;
    step(1);  // c2: OPND
    n_total++;
    if (instr_valid !== 1'b0 || rom_addr !== 7'd1)
      $display("FAIL call_opnd: got valid=%b addr=%0h, want valid=0 addr=1", instr_valid, rom_addr);
    else n_pass++;
    step(1);  // c3: FETCH at target
    n_total++;
    if (rom_addr !== 7'h10)
      $display("FAIL call_target: got addr=%0h, want 10", rom_addr);
    else n_pass++;
    step(2);  // c5: FETCH at return address
    n_total++;
    if (rom_addr !== 7'd2 || stack_err !== 1'b0 || halted !== 1'b0)
      $display("FAIL call_return: got addr=%0h err=%b halt=%b, want addr=2 err=0 halt=0",
               rom_addr, stack_err, halted);
    else n_pass++;
  endtask

  task automatic test_skz();
    for (int rr = 0; rr < 2; rr++) begin
      clear_rom();
      rom[4] = 8'hE0;
      run    = 1'b1;
      icu_rr = 1'(rr);
      do_reset();
      step(9);  // c9: EXEC SKZ
      n_total++;
      if (instr_valid !== 1'b1 || instr_op !== 4'hE)
        $display("FAIL skz_exec_rr%0d: got valid=%b op=%0h, want valid=1 op=e", rr, instr_valid, instr_op);
      else n_pass++;
      step(1);  // c10: next FETCH
      n_total++;
      if (rom_addr !== (rr == 0 ? 7'd6 : 7'd5))
        $display("FAIL skz_next_rr%0d: got addr=%0d, want %0d", rr, rom_addr, rr == 0 ? 6 : 5);
      else n_pass++;
    end
    icu_rr = 1'b0;
  endtask

  task automatic test_halt_flags();
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'hFF;
    run = 1'b1;
    do_reset();
    step(1);  // c1: EXEC NOP0
    n_total++;
    if ({instr_valid, flag0, flagf} !== 3'b110)
      $display("FAIL nop0_flag: got v/f0/ff=%b%b%b, want 110", instr_valid, flag0, flagf);
    else n_pass++;
    step(1);  // c2
    n_total++;
    if ({instr_valid, flag0, flagf} !== 3'b000)
      $display("FAIL nop0_pulse_end: got v/f0/ff=%b%b%b, want 000", instr_valid, flag0, flagf);
    else n_pass++;
    step(1);  // c3: EXEC NOPF F
    n_total++;
    if ({instr_valid, flag0, flagf, halted} !== 4'b1010)
      $display("FAIL nopf_flag: got v/f0/ff/h=%b%b%b%b, want 1010", instr_valid, flag0, flagf, halted);
    else n_pass++;
    for (int c = 0; c < 11; c++) begin
      step(1);
      n_total++;
      if (halted !== 1'b1 || rom_addr !== 7'd2 || instr_valid !== 1'b0 || flagf !== 1'b0)
        $display("FAIL halt_hold_%0d: got h=%b addr=%0d v=%b ff=%b, want h=1 addr=2 v=0 ff=0",
                 c, halted, rom_addr, instr_valid, flagf);
      else n_pass++;
    end
    rst = 1'b1;
    step(1);
    n_total++;
    if (halted !== 1'b0 || rom_addr !== 7'd0)
      $display("FAIL halt_reset: got h=%b addr=%0d, want h=0 addr=0", halted, rom_addr);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_stack_errors();
    clear_rom();
    rom[0] = 8'hD0;
    run = 1'b1;
    do_reset();
    step(2);  // c2: after RTN on empty stack
    n_total++;
    if (stack_err !== 1'b1 || halted !== 1'b1)
      $display("FAIL underflow: got err=%b halt=%b, want err=1 halt=1", stack_err, halted);
    else n_pass++;
    step(3);
    n_total++;
    if (stack_err !== 1'b1 || rom_addr !== 7'd1)
      $display("FAIL underflow_sticky: got err=%b addr=%0d, want err=1 addr=1", stack_err, rom_addr);
    else n_pass++;
    // Five nested calls: 0->4->8->12->16, the call at 16 overflows.
    clear_rom();
    for (int k = 0; k < 5; k++) begin
      rom[4 * k]     = 8'hC0;
      rom[4 * k + 1] = 8'h80 | 8'(4 * (k + 1));
    end
    do_reset();
    n_total++;
    if (stack_err !== 1'b0)
      $display("FAIL err_cleared_by_rst: got err=%b, want 0", stack_err);
    else n_pass++;
    step(12);  // c12: FETCH of 5th call
    n_total++;
    if (rom_addr !== 7'd16 || stack_err !== 1'b0 || halted !== 1'b0)
      $display("FAIL nest4: got addr=%0d err=%b halt=%b, want addr=16 err=0 halt=0",
               rom_addr, stack_err, halted);
    else n_pass++;
    step(3);  // c15: after overflowing OPND
    n_total++;
    if (rom_addr !== 7'd17 || stack_err !== 1'b1 || halted !== 1'b1)
      $display("FAIL overflow: got addr=%0d err=%b halt=%b, want addr=17 err=1 halt=1",
               rom_addr, stack_err, halted);
    else n_pass++;
  endtask

  task automatic test_wrap_stall();
    clear_rom();
    rom[0] = 8'hC0; rom[1] = 8'h7F; rom[127] = 8'h10;
    run = 1'b1;
    do_reset();
    step(3);  // c3: FETCH at 127
    n_total++;
    if (rom_addr !== 7'd127)
      $display("FAIL wrap_jmp: got addr=%0d, want 127", rom_addr);
    else n_pass++;
    step(1);  // c4: EXEC of byte 127, pc wrapped
    n_total++;
    if (rom_addr !== 7'd0 || instr_valid !== 1'b1 || {instr_op, instr_addr} !== 8'h10)
      $display("FAIL wrap_exec: got addr=%0d v=%b instr=%0h%0h, want addr=0 v=1 instr=10",
               rom_addr, instr_valid, instr_op, instr_addr);
    else n_pass++;
    // Stall from reset with run low.
    clear_rom();
    rom[0] = 8'h38;
    run = 1'b0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1);
      n_total++;
      if (instr_valid !== 1'b0 || rom_addr !== 7'd0)
        $display("FAIL stall_%0d: got v=%b addr=%0d, want v=0 addr=0", c, instr_valid, rom_addr);
      else n_pass++;
    end
    run = 1'b1;
    step(1);
    n_total++;
    if (instr_valid !== 1'b1 || {instr_op, instr_addr} !== 8'h38 || rom_addr !== 7'd1)
      $display("FAIL stall_resume: got v=%b instr=%0h%0h addr=%0d, want v=1 instr=38 addr=1",
               instr_valid, instr_op, instr_addr, rom_addr);
    else n_pass++;
    // Dropping run during EXEC completes the instruction, then stalls at the next FETCH.
    run = 1'b0;
    step(3);
    n_total++;
    if (instr_valid !== 1'b0 || rom_addr !== 7'd1)
      $display("FAIL stall_after_exec: got v=%b addr=%0d, want v=0 addr=1", instr_valid, rom_addr);
    else n_pass++;
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_linear();
    test_call_return();
    test_skz();
    test_halt_flags();
    test_stack_errors();
    test_wrap_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
